// File: rtl/keypad_encoder.sv
// keypad_encoder: 4x4 matrix keypad scanner with debounce, emitting PIN digit, enter and cancel pulses.
// Optional KEYPAD_DIGIT_COUNT_EN adds digit_count/pin_full and stops digits after four.
module keypad_encoder #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] digito,
    output logic       digito_stb,
    output logic       enter,
    output logic       cancel
`ifdef KEYPAD_DIGIT_COUNT_EN
    ,
    output logic [2:0] digit_count,
    output logic [0:0] pin_full
`endif
);
    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_WAIT_RELEASE} state_t;
    state_t state, state_n;
    logic [7:0] div;
    logic [1:0] col, key_row, low_row, clean;
    logic [3:0] deb, digit_q, key_val, row_pat;
    logic tick, one_low, blocked, emit, is_digit, full;

    assign tick = div == 8'(SCAN_DIV - 1);
    assign col_out = ~(4'b0001 << col);
    assign row_pat = ~(4'b0001 << key_row);
    assign one_low = row_in == 4'b1110 || row_in == 4'b1101 || row_in == 4'b1011 || row_in == 4'b0111;
    assign low_row = !row_in[0] ? 2'd0 : !row_in[1] ? 2'd1 : !row_in[2] ? 2'd2 : 2'd3;
    assign is_digit = (key_row != 2'd3 && col != 2'd3) || (key_row == 2'd3 && col == 2'd1);
    assign key_val = key_row == 2'd3 ? 4'd0 : {2'b00, key_row} * 4'd3 + {2'b00, col} + 4'd1;
    assign emit = state == S_EMIT && enable;
    assign digito_stb = emit && is_digit && !full;
    assign enter = emit && key_row == 2'd3 && col == 2'd2;
    assign cancel = emit && key_row == 2'd3 && col == 2'd0;
    assign digito = digito_stb ? key_val : digit_q;

    // A key found while blocked was already down when enable rose: go straight to release wait.
    always_comb begin
        state_n = state;
        if (!enable)
            state_n = S_SCAN;
        else
            case (state)
                S_SCAN:       if (tick && one_low) state_n = blocked ? S_WAIT_RELEASE : S_DEBOUNCE;
                S_DEBOUNCE:   if (tick) state_n = row_in != row_pat ? S_SCAN :
                                                  deb == 4'(DEBOUNCE - 1) ? S_EMIT : S_DEBOUNCE;
                S_EMIT:       state_n = S_WAIT_RELEASE;
                default:      if (tick && row_in == 4'hF && deb == 4'(DEBOUNCE - 1)) state_n = S_SCAN;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_SCAN;
            div     <= '0;
            col     <= '0;
            key_row <= '0;
            deb     <= '0;
            clean   <= '0;
            blocked <= 1'b0;
            digit_q <= '0;
        end else begin
            state   <= state_n;
            div     <= tick ? '0 : div + 8'd1;
            digit_q <= digito;
            if (tick && state_n == S_SCAN)
                col <= col + 2'd1;
            if (state == S_SCAN && state_n != S_SCAN)
                key_row <= low_row;
            if (!enable || state_n != state)
                deb <= '0;
            else if (tick && (state == S_DEBOUNCE || state == S_WAIT_RELEASE))
                deb <= (state == S_WAIT_RELEASE && row_in != 4'hF) ? '0 : deb + 4'd1;
            // Blocking lifts after a full key-free rotation or once the held key is captured.
            if (!enable) begin
                blocked <= 1'b1;
                clean   <= '0;
            end else if (state == S_SCAN && tick) begin
                clean <= row_in == 4'hF ? clean + 2'd1 : 2'd0;
                if (one_low || (row_in == 4'hF && clean == 2'd3))
                    blocked <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_DIGIT_COUNT_EN
    assign full = digit_count == 3'd4;
    assign pin_full = full;
    always_ff @(posedge clk) begin
        if (!reset || !enable || enter || cancel)
            digit_count <= '0;
        else if (digito_stb)
            digit_count <= digit_count + 3'd1;
    end
`else
    assign full = 1'b0;
`endif
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad matrix model, table vectors, corner sequences and a random event-level model.
module tb_keypad_encoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [3:0] row_in, col_out, digito;
    logic digito_stb, enter, cancel;
`ifdef KEYPAD_DIGIT_COUNT_EN
    logic [2:0] digit_count;
    logic [0:0] pin_full;
`endif
    logic [15:0] pressed = '0;
    int checks = 0, fails = 0;
    int n_stb = 0, n_ent = 0, n_can = 0, mcnt = 0;
    logic [3:0] last_dig = '0;
    int obs[$];
    int ex[$];
    // Key label per r*4+c: digit 0..9, 10 = enter (#), 11 = cancel (*), -1 = no output.
    int key_map[16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, 11, 0, 10, -1};

    typedef struct {int key; int stb; int ent; int can; int dig;} vec_t;
    vec_t vt[8];

    keypad_encoder dut (
        .clk(clk), .reset(reset), .enable(enable), .row_in(row_in), .col_out(col_out),
        .digito(digito), .digito_stb(digito_stb), .enter(enter), .cancel(cancel)
`ifdef KEYPAD_DIGIT_COUNT_EN
        , .digit_count(digit_count), .pin_full(pin_full)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (digito_stb) begin n_stb++; last_dig = digito; obs.push_back(int'(digito)); end
        if (enter) begin n_ent++; obs.push_back(10); end
        if (cancel) begin n_can++; obs.push_back(11); end
        if (reset) begin
            check("pulse_exclusive", int'($countones({digito_stb, enter, cancel}) <= 1), 1);
            check("col_onehot_low", $countones(~col_out), 1);
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic clr();
        n_stb = 0; n_ent = 0; n_can = 0; obs.delete();
    endtask

    task automatic press(int k, int hold, int gap);
        pressed[k] = 1'b1; tick(hold);
        pressed = '0; tick(gap);
    endtask

    function automatic void model_push(int k);
        int e;
        e = key_map[k];
        if (e < 0) return;
`ifdef KEYPAD_DIGIT_COUNT_EN
        if (e < 10) begin
            if (mcnt >= 4) return;
            mcnt++;
        end else mcnt = 0;
`endif
        ex.push_back(e);
    endfunction

    initial begin
        int lat, w, k, b;
        vt[0] = '{5, 1, 0, 0, 5};
        vt[1] = '{14, 0, 1, 0, 5};
        vt[2] = '{13, 1, 0, 0, 0};
        vt[3] = '{12, 0, 0, 1, 0};
        vt[4] = '{10, 1, 0, 0, 9};
        vt[5] = '{7, 0, 0, 0, 9};
        vt[6] = '{1, 1, 0, 0, 2};
        vt[7] = '{15, 0, 0, 0, 2};

        enable = 1'b1;
        tick(3);
        check("rst_col", int'(col_out), 4'b1110);
        check("rst_digito", int'(digito), 0);
        check("rst_pulses", int'({digito_stb, enter, cancel}), 0);

        // Key '1' held from reset: first sample at 16, then 4 debounce samples, pulse after the 80th edge.
        pressed[0] = 1'b1;
        reset = 1'b1;
        lat = 0;
        for (int i = 1; i <= 300 && lat == 0; i++) begin
            @(posedge clk); @(negedge clk);
            if (digito_stb) lat = i;
        end
        check("first_latency", lat, 80);
        check("first_digit", int'(digito), 1);
        pressed = '0; tick(150);

        for (int i = 0; i < 8; i++) begin
            clr();
            press(vt[i].key, 200, 150);
            check($sformatf("vec%0d_stb", i), n_stb, vt[i].stb);
            check($sformatf("vec%0d_enter", i), n_ent, vt[i].ent);
            check($sformatf("vec%0d_cancel", i), n_can, vt[i].can);
            check($sformatf("vec%0d_digito", i), int'(digito), vt[i].dig);
        end

        clr();
        for (int t = 0; t < 12; t++) begin pressed[8] = ~pressed[8]; tick(5); end
        press(8, 200, 150);
        check("bounce7_stb", n_stb, 1);
        check("bounce7_digit", int'(last_dig), 7);

        clr();
        pressed[0] = 1'b1; pressed[4] = 1'b1; tick(200);
        check("two_keys_none", n_stb + n_ent + n_can, 0);
        pressed[4] = 1'b0; tick(200);
        pressed = '0; tick(150);
        check("two_keys_release_stb", n_stb, 1);
        check("two_keys_release_digit", int'(last_dig), 1);

        clr();
        enable = 1'b0; pressed[10] = 1'b1; tick(50);
        enable = 1'b1; tick(300);
        check("held_at_enable_none", n_stb, 0);
        pressed = '0; tick(150);
        press(10, 200, 150);
        check("repress9_stb", n_stb, 1);
        check("repress9_digit", int'(last_dig), 9);

`ifdef KEYPAD_DIGIT_COUNT_EN
        reset = 1'b0; tick(2); reset = 1'b1;
        clr();
        press(0, 200, 150); press(1, 200, 150); press(2, 200, 150); press(4, 200, 150); press(5, 200, 150);
        check("pin_four_stb", n_stb, 4);
        check("pin_full", int'(pin_full), 1);
        check("pin_count4", int'(digit_count), 4);
        check("pin_last", int'(last_dig), 4);
        press(12, 200, 150);
        check("pin_cancel", n_can, 1);
        check("pin_count_clear", int'(digit_count), 0);
        clr();
        pressed[1] = 1'b1;
        w = 0;
        while (col_out != 4'b1101 && w < 200) begin tick(1); w++; end
        tick(17);
        check("deb_col_hold", int'(col_out), 4'b1101);
        reset = 1'b0; pressed = '0; tick(2);
        check("mid_deb_rst_col", int'(col_out), 4'b1110);
        check("mid_deb_rst_count", int'(digit_count), 0);
        reset = 1'b1; tick(200);
        check("mid_deb_no_pulse", n_stb, 0);
        mcnt = 0;
`endif

        clr(); ex.delete();
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 40));
            for (int t = 0; t < b; t++) begin pressed[k] = 1'($urandom_range(0, 1)); tick(1); end
            press(k, int'($urandom_range(140, 250)), int'($urandom_range(100, 160)));
            model_push(k);
        end
        check("rand_event_count", obs.size(), ex.size());
        for (int i = 0; i < ex.size() && i < obs.size(); i++)
            check($sformatf("rand_event%0d", i), obs[i], ex[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
